// File: rtl/chunked_serial_adder.sv
// chunked_serial_adder: WIDTH-bit add/sub, CHUNK bits per clock, valid/ready.
// Define CHUNK_ADDER_OVF_EN to register signed overflow; otherwise ovf is 0.
module chunked_serial_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] MASK = {WIDTH{1'b1}} >> (WIDTH - CHUNK);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_reg, b_reg, sum_r;
    logic             carry, cout_r;
    logic [CW-1:0]    cnt;
    logic [31:0]      base;
    logic [CHUNK-1:0] ach, bch;
    logic [CHUNK:0]   csum;
    logic             accept, last;

    assign accept    = in_valid && (state == IDLE);
    assign last      = (cnt == LAST);
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign sum       = sum_r;
    assign cout      = cout_r;

    // Current chunk slice, selected by shifting so the index stays word-wide.
    always_comb begin
        base = 32'(cnt) * 32'(CHUNK);
        ach  = CHUNK'(a_reg >> base);
        bch  = CHUNK'(b_reg >> base);
        csum = {1'b0, ach} + {1'b0, bch} + {{CHUNK{1'b0}}, carry};
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (in_valid)  state_nx = CALC;
            CALC:    if (last)      state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_reg  <= '0;
            b_reg  <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_r  <= '0;
            cout_r <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                a_reg <= a;
                b_reg <= sub ? ~b : b;
                carry <= cin ^ sub;
                cnt   <= '0;
            end else if (state == CALC) begin
                sum_r <= (sum_r & ~(MASK << base))
                       | (WIDTH'(csum[CHUNK-1:0]) << base);
                carry <= csum[CHUNK];
                cnt   <= cnt + CW'(1);
                if (last) cout_r <= csum[CHUNK];
            end
        end
    end

`ifdef CHUNK_ADDER_OVF_EN
    logic ovf_r;

    // Carry into the MSB is recovered as sum ^ a ^ b at that bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_r <= 1'b0;
        end else if (state == CALC && last) begin
            ovf_r <= csum[CHUNK]
                   ^ (csum[CHUNK-1] ^ ach[CHUNK-1] ^ bch[CHUNK-1]);
        end
    end

    assign ovf = ovf_r;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_chunked_serial_adder.sv
// tb_chunked_serial_adder: directed checks of chunked_serial_adder
// with CHUNK=2 and CHUNK=8 instances sharing operand inputs.
module tb_chunked_serial_adder;
    typedef struct {
        logic [7:0] s;
        logic       c;
        logic       o;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       iv0, iv1;
    logic [7:0] a, b;
    logic       cin, sub, out_ready;

    logic       ir0, ov0, co0, of0, bz0;
    logic [7:0] sm0;
    logic       ir1, ov1, co1, of1, bz1;
    logic [7:0] sm1;

    int         sel;
    logic       ir_s, ov_s, co_s, of_s;
    logic [7:0] sm_s;

    int   passed = 0;
    int   total  = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    chunked_serial_adder #(.WIDTH(8), .CHUNK(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(ov0), .out_ready(out_ready),
        .sum(sm0), .cout(co0), .ovf(of0), .busy(bz0)
    );

    chunked_serial_adder #(.WIDTH(8), .CHUNK(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(ov1), .out_ready(out_ready),
        .sum(sm1), .cout(co1), .ovf(of1), .busy(bz1)
    );

    assign ir_s = (sel != 0) ? ir1 : ir0;
    assign ov_s = (sel != 0) ? ov1 : ov0;
    assign sm_s = (sel != 0) ? sm1 : sm0;
    assign co_s = (sel != 0) ? co1 : co0;
    assign of_s = (sel != 0) ? of1 : of0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic exp_t model(logic [7:0] av, logic [7:0] bv,
                                   logic ci, logic sb);
        exp_t       e;
        logic [7:0] bb;
        logic [8:0] r;
        bb  = sb ? ~bv : bv;
        r   = {1'b0, av} + {1'b0, bb} + {8'd0, ci ^ sb};
        e.s = r[7:0];
        e.c = r[8];
`ifdef CHUNK_ADDER_OVF_EN
        e.o = (av[7] == bb[7]) && (r[7] != av[7]);
`else
        e.o = 1'b0;
`endif
        return e;
    endfunction

    task automatic pop_cmp();
        exp_t e;
        chk("sb_nonempty", 32'(q.size() != 0), 1);
        if (q.size() != 0) begin
            e = q.pop_front();
            chk("out_valid", 32'(ov_s), 1);
            chk("sum", 32'(sm_s), 32'(e.s));
            chk("cout", 32'(co_s), 32'(e.c));
            chk("ovf", 32'(of_s), 32'(e.o));
        end
    endtask

    task automatic run_op(int s, logic [7:0] av, logic [7:0] bv,
                          logic ci, logic sb, int exp_lat);
        int lat;
        @(negedge clk);
        sel = s;
        a   = av;
        b   = bv;
        cin = ci;
        sub = sb;
        #1;
        chk("in_ready_idle", 32'(ir_s), 1);
        if (s != 0) iv1 = 1'b1;
        else        iv0 = 1'b1;
        q.push_back(model(av, bv, ci, sb));
        @(posedge clk);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            iv0 = 1'b0;
            iv1 = 1'b0;
        end while (!ov_s && lat < 20);
        chk("latency", 32'(lat), 32'(exp_lat));
        if (out_ready) begin
            pop_cmp();
            @(posedge clk);
            @(negedge clk);
            chk("back_idle", 32'(ir_s), 1);
            chk("valid_drop", 32'(ov_s), 0);
        end
    endtask

    initial begin
        exp_t e;
        rst_n     = 1'b0;
        iv0       = 1'b0;
        iv1       = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b1;
        sel       = 0;

        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(ir0), 1);
        chk("rst_out_valid", 32'(ov0), 0);
        chk("rst_busy", 32'(bz0), 0);
        chk("rst_sum", 32'(sm0), 0);
        chk("rst_cout", 32'(co0), 0);
        chk("rst_ovf", 32'(of0), 0);
        chk("rst_out_valid1", 32'(ov1), 0);
        rst_n = 1'b1;

        run_op(0, 8'hFF, 8'h01, 1'b0, 1'b0, 4);
        run_op(0, 8'h7F, 8'h01, 1'b0, 1'b0, 4);
        run_op(0, 8'h05, 8'h07, 1'b0, 1'b1, 4);
        run_op(0, 8'h07, 8'h05, 1'b1, 1'b1, 4);
        run_op(0, 8'h80, 8'h80, 1'b1, 1'b0, 4);

        // Backpressure: result must stay frozen, new requests ignored.
        out_ready = 1'b0;
        run_op(0, 8'h3C, 8'h11, 1'b0, 1'b0, 4);
        e = model(8'h3C, 8'h11, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(ov0), 1);
            chk("bp_in_ready", 32'(ir0), 0);
            chk("bp_sum", 32'(sm0), 32'(e.s));
            chk("bp_cout", 32'(co0), 32'(e.c));
            a   = 8'($urandom);
            b   = 8'($urandom);
            iv0 = (i % 2 == 0);
        end
        @(negedge clk);
        iv0       = 1'b0;
        out_ready = 1'b1;
        pop_cmp();
        @(posedge clk);
        @(negedge clk);
        chk("bp_release_idle", 32'(ir0), 1);
        chk("bp_release_valid", 32'(ov0), 0);
        repeat (4) @(negedge clk);
        chk("bp_no_second_op", 32'(ov0), 0);
        chk("bp_no_busy", 32'(bz0), 0);

        // Reset during the second CALC cycle discards the operation.
        @(negedge clk);
        a   = 8'h99;
        b   = 8'h66;
        iv0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv0 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_busy", 32'(bz0), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(ov0), 0);
        chk("mid_rst_busy", 32'(bz0), 0);
        chk("mid_rst_sum", 32'(sm0), 0);
        chk("mid_rst_ready", 32'(ir0), 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("mid_rst_no_result", 32'(ov0), 0);
        run_op(0, 8'h10, 8'h20, 1'b0, 1'b0, 4);

        run_op(1, 8'hAA, 8'h55, 1'b1, 1'b0, 1);
        run_op(1, 8'h7F, 8'h01, 1'b0, 1'b0, 1);
        run_op(1, 8'h05, 8'h07, 1'b0, 1'b1, 1);

        chk("sb_drained", 32'(q.size()), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
